// File: rtl/perceptron_pkg.sv
// Shared constants for the shift-weighted perceptron digit classifier:
// class count, weight shifts, controller states and the sum-to-class table.
package perceptron_pkg;

  localparam int         NUM_CLASSES = 10;
  localparam logic [3:0] CLASS_NONE  = 4'hF;

  localparam int EDGE_SHIFT  = 3;
  localparam int CURVE_SHIFT = 1;

  typedef enum logic [1:0] {ACCUM, SCAN, OUT} state_t;

  // Entry i is the weighted sum that identifies digit i; all entries are distinct.
  localparam logic [NUM_CLASSES-1:0][6:0] CLASS_SUM = {
    7'd26, 7'd64, 7'd4, 7'd40, 7'd28, 7'd6, 7'd34, 7'd20, 7'd2, 7'd32
  };

endpackage

// File: rtl/perceptron_lut.sv
// Combinational classifier: shift-weighted feature sum matched against the class table.
// Zero latency; no flow control of its own.
module perceptron_lut
  import perceptron_pkg::*;
(
  input  logic [2:0] edges,
  input  logic [3:0] curves,
  output logic       hit,
  output logic [3:0] cls
);

  logic [6:0] sum;

  always_comb begin
    sum = ({4'b0, edges} << EDGE_SHIFT) + ({3'b0, curves} << CURVE_SHIFT);
    hit = 1'b0;
    cls = CLASS_NONE;
    for (int i = 0; i < NUM_CLASSES; i++) begin
      if (sum == CLASS_SUM[i]) begin
        hit = 1'b1;
        cls = 4'(i);
      end
    end
  end

endmodule

// File: rtl/perceptron_vote_ctrl.sv
// Frame vote controller: classifies FRAME samples, scans 10 counters, holds the majority result until taken.
// Result valid 10 cycles after the last accept; in_ready/out_valid come from state only. Optional PERCEPTRON_STATS_EN.
module perceptron_vote_ctrl
  import perceptron_pkg::*;
#(
  parameter int FRAME = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [2:0] in_edges,
  input  logic [3:0] in_curves,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [3:0] out_class,
  output logic [3:0] out_votes,
  output logic       out_miss,
  output logic [7:0] stat_miss
);

  state_t     state, state_nxt;
  logic [3:0] votes [NUM_CLASSES];
  logic [3:0] samp_cnt;
  logic [3:0] scan_idx;
  logic [3:0] best_cls, best_votes;
  logic [3:0] nb_cls, nb_votes;
  logic       lut_hit;
  logic [3:0] lut_cls;
  logic       accept, last_samp, scan_done;

  perceptron_lut u_lut (
    .edges  (in_edges),
    .curves (in_curves),
    .hit    (lut_hit),
    .cls    (lut_cls)
  );

  assign accept    = (state == ACCUM) && in_valid;
  assign last_samp = (samp_cnt == 4'(FRAME - 1));
  assign scan_done = (scan_idx == 4'(NUM_CLASSES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ACCUM;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      ACCUM: begin
        in_ready = 1'b1;
        if (in_valid && last_samp) state_nxt = SCAN;
      end
      SCAN: if (scan_done) state_nxt = OUT;
      OUT: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = ACCUM;
      end
      default: state_nxt = ACCUM;
    endcase
  end

  // Strictly-greater compare keeps the lowest index on ties.
  always_comb begin
    nb_cls   = best_cls;
    nb_votes = best_votes;
    if (votes[scan_idx] > best_votes) begin
      nb_cls   = scan_idx;
      nb_votes = votes[scan_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CLASSES; i++) votes[i] <= '0;
      samp_cnt   <= '0;
      scan_idx   <= '0;
      best_cls   <= CLASS_NONE;
      best_votes <= '0;
      out_class  <= CLASS_NONE;
      out_votes  <= '0;
      out_miss   <= 1'b0;
    end else begin
      case (state)
        ACCUM: if (accept) begin
          if (lut_hit) votes[lut_cls] <= votes[lut_cls] + 4'd1;
          samp_cnt <= samp_cnt + 4'd1;
          if (last_samp) begin
            scan_idx   <= '0;
            best_cls   <= CLASS_NONE;
            best_votes <= '0;
          end
        end
        SCAN: begin
          best_cls   <= nb_cls;
          best_votes <= nb_votes;
          scan_idx   <= scan_idx + 4'd1;
          if (scan_done) begin
            out_class <= (nb_votes == 4'd0) ? CLASS_NONE : nb_cls;
            out_votes <= nb_votes;
            out_miss  <= (nb_votes == 4'd0);
          end
        end
        OUT: if (out_ready) begin
          for (int i = 0; i < NUM_CLASSES; i++) votes[i] <= '0;
          samp_cnt <= '0;
        end
        default: ;
      endcase
    end
  end

`ifdef PERCEPTRON_STATS_EN
  logic [7:0] miss_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                                      miss_cnt <= '0;
    else if (accept && !lut_hit && miss_cnt != 8'hFF) miss_cnt <= miss_cnt + 8'd1;
  end

  assign stat_miss = miss_cnt;
`else
  assign stat_miss = 8'd0;
`endif

endmodule

// File: tb/tb_perceptron_vote_ctrl.sv
// Directed bench for perceptron_vote_ctrl with hand-computed frame results.
module tb_perceptron_vote_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_edges;
  logic [3:0] in_curves;
  logic       out_valid;
  logic       out_ready;
  logic [3:0] out_class;
  logic [3:0] out_votes;
  logic       out_miss;
  logic [7:0] stat_miss;

  int n_cmp = 0;
  int n_err = 0;
  int lat;

`ifdef PERCEPTRON_STATS_EN
  localparam logic [7:0] EXP_STAT = 8'd8;
`else
  localparam logic [7:0] EXP_STAT = 8'd0;
`endif

  always #5 clk = ~clk;

  perceptron_vote_ctrl #(.FRAME(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_edges  (in_edges),
    .in_curves (in_curves),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_class (out_class),
    .out_votes (out_votes),
    .out_miss  (out_miss),
    .stat_miss (stat_miss)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic send(input logic [2:0] e, input logic [3:0] c);
    int n = 0;
    in_valid  = 1'b1;
    in_edges  = e;
    in_curves = c;
    while (!in_ready && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) chk("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int cycles);
    cycles = 0;
    while (!out_valid && cycles < 40) begin
      @(posedge clk); #1;
      cycles++;
    end
    chk("out_valid_seen", 32'(out_valid), 32'd1);
  endtask

  task automatic take_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("in_ready_after_take", 32'(in_ready), 32'd1);
    chk("out_valid_after_take", 32'(out_valid), 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [3:0] cls,
                              input logic [3:0] vts, input logic miss);
    chk({tag, "_class"}, 32'(out_class), 32'(cls));
    chk({tag, "_votes"}, 32'(out_votes), 32'(vts));
    chk({tag, "_miss"},  32'(out_miss),  32'(miss));
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"},  32'(in_ready),  32'd1);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_class"},     32'(out_class), 32'hF);
    chk({tag, "_votes"},     32'(out_votes), 32'd0);
    chk({tag, "_miss"},      32'(out_miss),  32'd0);
    chk({tag, "_stat"},      32'(stat_miss), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_edges  = '0;
    in_curves = '0;
    out_ready = 1'b0;
    #12;
    check_reset_outputs("rst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // (4,0): sum 32 -> class 0, all eight votes
    for (int i = 0; i < 8; i++) send(3'd4, 4'd0);
    wait_out(lat);
    chk("f1_latency", 32'(lat), 32'd10);
    check_result("f1", 4'd0, 4'd8, 1'b0);
    take_out();

    // (3,1)=26 -> class 9 x3, (0,1)=2 -> class 1 x5
    for (int i = 0; i < 3; i++) send(3'd3, 4'd1);
    for (int i = 0; i < 5; i++) send(3'd0, 4'd1);
    wait_out(lat);
    check_result("f2", 4'd1, 4'd5, 1'b0);
    take_out();

    // (5,0)=40 -> class 6, (7,4)=64 -> class 8; tie goes to 6
    for (int i = 0; i < 4; i++) send(3'd7, 4'd4);
    for (int i = 0; i < 4; i++) send(3'd5, 4'd0);
    wait_out(lat);
    check_result("tie", 4'd6, 4'd4, 1'b0);
    take_out();

    // (1,0)=8 matches nothing
    for (int i = 0; i < 8; i++) send(3'd1, 4'd0);
    wait_out(lat);
    check_result("miss", 4'hF, 4'd0, 1'b1);
    chk("miss_stat", 32'(stat_miss), 32'(EXP_STAT));

    // Stall in OUT with a source pushing samples that must be ignored
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      in_edges  = 3'(i);
      in_curves = 4'(i);
      @(posedge clk); #1;
      chk("hold_out_valid", 32'(out_valid), 32'd1);
      chk("hold_in_ready",  32'(in_ready),  32'd0);
      chk("hold_class",     32'(out_class), 32'hF);
      chk("hold_votes",     32'(out_votes), 32'd0);
    end
    in_valid = 1'b0;
    chk("hold_stat", 32'(stat_miss), 32'(EXP_STAT));
    take_out();

    // Partial frame discarded by reset
    for (int i = 0; i < 5; i++) send(3'd4, 4'd0);
    rst_n = 1'b0;
    #2;
    check_reset_outputs("midrst");
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk); #1;

    // (2,2)=20 -> class 2; leftover counts would end the frame early as class 0
    for (int i = 0; i < 8; i++) send(3'd2, 4'd2);
    wait_out(lat);
    chk("f5_latency", 32'(lat), 32'd10);
    check_result("f5", 4'd2, 4'd8, 1'b0);
    take_out();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
